// File: rtl/vm_pkg.sv
// Shared vending-machine coin definitions: denominations, their values and
// the change dispenser state encoding.
package vm_pkg;

  // Hopper coin select code, ordered smallest to largest denomination.
  typedef enum logic [1:0] {
    COIN_1  = 2'd0,
    COIN_5  = 2'd1,
    COIN_10 = 2'd2,
    COIN_20 = 2'd3
  } coin_t;

  localparam int NUM_DENOM = 4;
  localparam int VALUE_1   = 1;
  localparam int VALUE_5   = 5;
  localparam int VALUE_10  = 10;
  localparam int VALUE_20  = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } disp_state_t;

  // Face value in units of a coin select code.
  function automatic int coin_value(input coin_t c);
    case (c)
      COIN_1:  return VALUE_1;
      COIN_5:  return VALUE_5;
      COIN_10: return VALUE_10;
      default: return VALUE_20;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest available denomination that does not
// exceed the remaining amount. o_none flags that no denomination qualifies.
module coin_select
  import vm_pkg::*;
#(
  parameter int AMOUNT_W = 7
) (
  input  logic [AMOUNT_W-1:0]  i_remaining,
  input  logic [NUM_DENOM-1:0] i_avail,
  output coin_t                o_sel,
  output logic [AMOUNT_W-1:0]  o_value,
  output logic                 o_none
);

  logic [NUM_DENOM-1:0] w_fit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DENOM; gi++) begin : g_fit
      assign w_fit[gi] = i_avail[gi] &&
                         (i_remaining >= AMOUNT_W'(coin_value(coin_t'(2'(gi)))));
    end
  endgenerate

  // Priority pick: scanning upward lets the largest fitting denomination win.
  always_comb begin
    o_sel   = COIN_1;
    o_value = '0;
    o_none  = 1'b1;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (w_fit[i]) begin
        o_sel   = coin_t'(2'(i));
        o_value = AMOUNT_W'(coin_value(coin_t'(2'(i))));
        o_none  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a refund amount one coin per hopper handshake,
// greedy largest-first over 20/10/5/1. Reports progress, done, ack-timeout
// fault and (with inventory) out-of-stock shortfall.
// Optional feature macro: CHANGE_INVENTORY_EN (per-denomination stock counters).
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMOUNT_W    = 7,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int STOCK_W     = 6,
  parameter int STOCK_INIT  = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [AMOUNT_W-1:0] req_amount,
  output logic                req_ready,
  output logic                coin_valid,
  output logic [1:0]          coin_sel,
  input  logic                coin_ack,
  output logic [AMOUNT_W-1:0] remaining,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic                shortfall,
  input  logic                stock_refill
);

  // One counter serves both the ack wait and the post-coin gap.
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  disp_state_t         r_state,       w_state_next;
  logic [AMOUNT_W-1:0] r_remaining,   w_remaining_next;
  logic                r_coin_valid,  w_coin_valid_next;
  coin_t               r_coin_sel,    w_coin_sel_next;
  logic                r_fault,       w_fault_next;
  logic                r_shortfall,   w_shortfall_next;
  logic [CNT_W-1:0]    r_cnt,         w_cnt_next;

  logic [NUM_DENOM-1:0] w_avail;
  coin_t                w_pick_sel;
  logic [AMOUNT_W-1:0]  w_pick_value;
  logic                 w_pick_none;
  logic [AMOUNT_W-1:0]  w_issue_value;

  coin_select #(.AMOUNT_W(AMOUNT_W)) u_coin_select (
    .i_remaining (r_remaining),
    .i_avail     (w_avail),
    .o_sel       (w_pick_sel),
    .o_value     (w_pick_value),
    .o_none      (w_pick_none)
  );

  // Value of the coin currently offered; it was picked as <= remaining and
  // remaining does not change while it is offered, so the subtract never wraps.
  assign w_issue_value = AMOUNT_W'(coin_value(r_coin_sel));

`ifdef CHANGE_INVENTORY_EN
  logic w_ack_take;
  assign w_ack_take = (r_state == ST_ISSUE) && coin_ack;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DENOM; gi++) begin : g_stock
      logic [STOCK_W-1:0] r_stock;

      // Per-denomination stock: refill beats a same-cycle payout, saturates at 0.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_stock <= STOCK_W'(STOCK_INIT);
        end else if (stock_refill) begin
          r_stock <= STOCK_W'(STOCK_INIT);
        end else if (w_ack_take && (r_coin_sel == coin_t'(2'(gi))) && (r_stock != '0)) begin
          r_stock <= r_stock - STOCK_W'(1);
        end
      end

      assign w_avail[gi] = (r_stock != '0);
    end
  endgenerate
`else
  // Unlimited stock: every denomination is always available.
  logic w_unused;
  assign w_avail  = '1;
  assign w_unused = stock_refill ^ (STOCK_W > 0) ^ (STOCK_INIT > 0);
`endif

  // State and datapath registers; reset aborts any payout in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_coin_valid <= 1'b0;
      r_coin_sel   <= COIN_1;
      r_fault      <= 1'b0;
      r_shortfall  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_remaining  <= w_remaining_next;
      r_coin_valid <= w_coin_valid_next;
      r_coin_sel   <= w_coin_sel_next;
      r_fault      <= w_fault_next;
      r_shortfall  <= w_shortfall_next;
      r_cnt        <= w_cnt_next;
    end
  end

  // Next-state logic: accept, pick a coin, wait for ack or timeout, settle gap.
  always_comb begin
    w_state_next      = r_state;
    w_remaining_next  = r_remaining;
    w_coin_valid_next = r_coin_valid;
    w_coin_sel_next   = r_coin_sel;
    w_fault_next      = r_fault;
    w_shortfall_next  = r_shortfall;
    w_cnt_next        = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_remaining_next = req_amount;
          w_fault_next     = 1'b0;
          w_shortfall_next = 1'b0;
          w_state_next     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (r_remaining == '0) begin
          w_state_next = ST_FINISH;
        end else if (w_pick_none) begin
          w_shortfall_next = 1'b1;
          w_state_next     = ST_FINISH;
        end else begin
          w_coin_sel_next   = w_pick_sel;
          w_coin_valid_next = 1'b1;
          w_cnt_next        = '0;
          w_state_next      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (coin_ack) begin
          w_remaining_next  = r_remaining - w_issue_value;
          w_coin_valid_next = 1'b0;
          w_cnt_next        = '0;
          w_state_next      = ST_GAP;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_fault_next      = 1'b1;
          w_coin_valid_next = 1'b0;
          w_state_next      = ST_FINISH;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          w_cnt_next   = '0;
          w_state_next = ST_SELECT;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FINISH);
  assign coin_valid = r_coin_valid;
  assign coin_sel   = r_coin_sel;
  assign remaining  = r_remaining;
  assign fault      = r_fault;
  assign shortfall  = r_shortfall;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected coins and
// completion records computed by a greedy reference model; a negedge monitor
// pops and compares whenever the DUT raises coin_valid or done.
// Honours CHANGE_INVENTORY_EN for the stock-limited model and extra scenarios.
module tb_change_dispenser;

  localparam int AMOUNT_W    = 7;
  localparam int GAP_CYCLES  = 4;
  localparam int ACK_TIMEOUT = 255;
  localparam int STOCK_W     = 6;
  localparam int STOCK_INIT  = 20;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid = 1'b0;
  logic [AMOUNT_W-1:0] req_amount = '0;
  logic                req_ready;
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                coin_ack = 1'b0;
  logic [AMOUNT_W-1:0] remaining;
  logic                busy;
  logic                done;
  logic                fault;
  logic                shortfall;
  logic                stock_refill = 1'b0;

  change_dispenser #(
    .AMOUNT_W(AMOUNT_W), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT),
    .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .coin_ack(coin_ack), .remaining(remaining), .busy(busy), .done(done),
    .fault(fault), .shortfall(shortfall), .stock_refill(stock_refill)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int sel; int rem; } coin_exp_t;
  typedef struct { int fault; int shortfall; int rem; } done_exp_t;

  coin_exp_t q_coin[$];
  done_exp_t q_done[$];
  int den[4] = '{1, 5, 10, 20};
  int m_stock[4];

  function automatic bit has_stock(input int k);
`ifdef CHANGE_INVENTORY_EN
    return m_stock[k] > 0;
`else
    return k >= 0;
`endif
  endfunction

  task automatic model_reset_stock();
    for (int k = 0; k < 4; k++) m_stock[k] = STOCK_INIT;
  endtask

  // Greedy payout by plain arithmetic; never_ack models a hopper that stalls.
  task automatic model_request(input int amt, input bit never_ack, output bit short_o);
    int rem;
    int pick;
    coin_exp_t c;
    done_exp_t d;
    rem = amt;
    d.fault = 0;
    d.shortfall = 0;
    while (rem > 0) begin
      pick = -1;
      for (int k = 3; k >= 0; k--)
        if (pick < 0 && den[k] <= rem && has_stock(k)) pick = k;
      if (pick < 0) begin
        d.shortfall = 1;
        break;
      end
      c.sel = pick;
      c.rem = rem;
      q_coin.push_back(c);
      if (never_ack) begin
        d.fault = 1;
        break;
      end
      rem -= den[pick];
      m_stock[pick]--;
    end
    d.rem = rem;
    q_done.push_back(d);
    short_o = d.shortfall[0];
  endtask

  // ---------------- hopper responder ----------------
  bit ack_never = 1'b0;
  int ack_delay = 1;
  int ack_wait  = 0;

  always @(negedge clk) begin
    if (!rst || ack_never || !coin_valid) begin
      coin_ack = 1'b0;
      ack_wait = 0;
    end else if (ack_wait >= ack_delay) begin
      coin_ack = 1'b1;
    end else begin
      ack_wait++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_cv = 1'b0;
  logic       prev_done = 1'b0;
  logic [1:0] prev_sel = 2'd0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_cv   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (coin_valid && !prev_cv) begin
        if (q_coin.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_coin: got coin_sel=%0d remaining=%0d, expected no coin", coin_sel, remaining);
        end else begin : b_coin
          coin_exp_t e;
          e = q_coin.pop_front();
          check("coin_sel", coin_sel, e.sel);
          check("coin_remaining", remaining, e.rem);
        end
      end
      if (coin_valid && prev_cv) check("coin_sel_stable", coin_sel, prev_sel);
      if (done) begin
        if (prev_done) check("done_one_cycle", prev_done, 0);
        if (q_done.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin : b_done
          done_exp_t e;
          e = q_done.pop_front();
          $display("txn done: remaining=%0d fault=%0d shortfall=%0d", remaining, fault, shortfall);
          check("done_fault", fault, e.fault);
          check("done_shortfall", shortfall, e.shortfall);
          check("done_remaining", remaining, e.rem);
          check("done_coin_valid", coin_valid, 0);
        end
      end
      prev_cv   = coin_valid;
      prev_sel  = coin_sel;
      prev_done = done;
    end
  end

  // ---------------- driver helpers ----------------
  // Called at a negedge; returns just after the accepting posedge.
  task automatic send_req(input int amt, input bit never_ack);
    bit s;
    int t;
    t = 0;
    while (!req_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("req_ready_timeout", req_ready, 1);
    model_request(amt, never_ack, s);
    ack_never  = never_ack;
    req_valid  = 1'b1;
    req_amount = AMOUNT_W'(amt);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == budget) check("done_timeout", done, 1);
  endtask

  task automatic pulse_refill();
    @(negedge clk);
    stock_refill = 1'b1;
    @(negedge clk);
    stock_refill = 1'b0;
`ifdef CHANGE_INVENTORY_EN
    model_reset_stock();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int amt;
    bit s;
    model_reset_stock();

    // Reset state, both during and after reset.
    repeat (3) @(negedge clk);
    check("rst_coin_valid", coin_valid, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_coin_valid", coin_valid, 0);
    check("reset_coin_sel", coin_sel, 0);
    check("reset_remaining", remaining, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fault", fault, 0);
    check("reset_shortfall", shortfall, 0);

    // 37 units, ack one cycle after each coin: 20,10,5,1,1 and first-coin latency.
    ack_delay = 1;
    send_req(37, 0);
    @(negedge clk);
    check("lat37_cv_low", coin_valid, 0);
    check("lat37_busy", busy, 1);
    @(negedge clk);
    check("lat37_cv_high", coin_valid, 1);
    wait_done(500);
    @(negedge clk);
    check("a37_req_ready", req_ready, 1);

    // Zero amount: no coin, done two cycles after accept.
    send_req(0, 0);
    @(negedge clk);
    check("zero_done_early", done, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    @(negedge clk);
    check("zero_req_ready", req_ready, 1);
    check("zero_done_clear", done, 0);

    // 12 units with a stalled hopper: ack timeout fault.
    send_req(12, 1);
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) break;
      if (coin_valid) cnt++;
    end
    check("timeout_cycles", cnt, ACK_TIMEOUT);
    check("timeout_fault", fault, 1);
    check("timeout_remaining", remaining, 12);
    @(negedge clk);
    check("fault_sticky", fault, 1);
    check("timeout_req_ready", req_ready, 1);
    ack_never = 1'b0;

    // Request while busy is dropped; also clears the previous fault.
    ack_delay = 2;
    send_req(20, 0);
    req_valid  = 1'b1;
    req_amount = AMOUNT_W'(9);
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_done(500);
    repeat (4) @(negedge clk);
    check("busy_ignored_idle", busy, 0);

    // Asynchronous reset while a coin is offered.
    send_req(30, 1);
    cnt = 0;
    while (!coin_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_cv_seen", coin_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_cv_drop", coin_valid, 0);
    check("abort_req_ready", req_ready, 1);
    q_coin.delete();
    q_done.delete();
    model_reset_stock();
    ack_never = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_remaining", remaining, 0);
    check("abort_done", done, 0);

    // Randomized requests with random hopper latency.
    for (int n = 0; n < 30; n++) begin
      amt       = $urandom_range(0, 127);
      ack_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) pulse_refill();
      send_req(amt, 0);
      wait_done(2000);
      @(negedge clk);
    end

`ifdef CHANGE_INVENTORY_EN
    // Empty the 20u stock, then 25 must pay 10,10,5.
    pulse_refill();
    ack_delay = 0;
    for (int n = 0; n < STOCK_INIT; n++) begin
      send_req(20, 0);
      wait_done(500);
      @(negedge clk);
    end
    send_req(25, 0);
    wait_done(500);
    @(negedge clk);
    // Drain everything until the model predicts a shortfall, then refill.
    for (int n = 0; n < 12; n++) begin
      model_request(0, 0, s);
      void'(q_done.pop_back());
      send_req(127, 0);
      wait_done(3000);
      @(negedge clk);
      if (q_done.size() == 0 && shortfall) break;
    end
    pulse_refill();
    send_req(37, 0);
    wait_done(500);
    @(negedge clk);
`endif

    check("coin_queue_empty", q_coin.size(), 0);
    check("done_queue_empty", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
